// File: rtl/k2red_pkg.sv
// Shared K2-RED helpers: multiplier latency and half-width split, reused by the
// reducer-integration top to keep valid aligned through the whole datapath.
package k2red_pkg;

  localparam int unsigned LOG_Q_DEF = 32;
  localparam int unsigned HALF      = LOG_Q_DEF / 2;

  function automatic int unsigned k2red_half(int unsigned log_q);
    return log_q / 2;
  endfunction

  function automatic int unsigned k2red_mult_lat(int unsigned speed_opt);
    return (speed_opt != 0) ? 4 : 3;
  endfunction

endpackage

// File: rtl/k2red_pre_mult_if.sv
// Operand/sideband bundle between a producer and the K2-RED pre-multiplier.
interface k2red_pre_mult_if #(
  parameter int unsigned LOG_Q = 32,
  parameter int unsigned LOG_L = 4
);
  logic                 in_valid;
  logic [LOG_Q-1:0]     X;
  logic [LOG_Q-1:0]     Y;
  logic [LOG_Q-1:0]     Q;
  logic [LOG_L-1:0]     l1;
  logic [LOG_L-1:0]     l2;
  logic [LOG_L-1:0]     l3;
  logic                 out_valid;
  logic [2*LOG_Q-1:0]   A;
  logic [LOG_Q-1:0]     Q_o;
  logic [LOG_L-1:0]     l1_o;
  logic [LOG_L-1:0]     l2_o;
  logic [LOG_L-1:0]     l3_o;
  logic                 range_err;

  modport master (
    output in_valid, X, Y, Q, l1, l2, l3,
    input  out_valid, A, Q_o, l1_o, l2_o, l3_o, range_err
  );

  modport slave (
    input  in_valid, X, Y, Q, l1, l2, l3,
    output out_valid, A, Q_o, l1_o, l2_o, l3_o, range_err
  );
endinterface

// File: rtl/k2red_pmul_half.sv
// Registered HxH unsigned multiply sized for one DSP tile; no reset so it maps
// cleanly onto the DSP output register.
module k2red_pmul_half #(
  parameter int unsigned H = 16
) (
  input  logic           clk,
  input  logic [H-1:0]   a_i,
  input  logic [H-1:0]   b_i,
  output logic [2*H-1:0] p_o
);

  always_ff @(posedge clk) begin
    p_o <= a_i * b_i;
  end

endmodule

// File: rtl/k2red_pre_mult.sv
// Pipelined LOG_Q x LOG_Q multiplier feeding the K2-RED shift reducer; Q and l1..l3
// travel in a delay line so they leave aligned with the product A.
module k2red_pre_mult
  import k2red_pkg::*;
#(
  parameter int unsigned LOG_Q     = 32,
  parameter int unsigned LOG_L     = 4,
  parameter int unsigned SPEED_OPT = 1
) (
  input logic             clk,
  input logic             rst,
  k2red_pre_mult_if.slave bus
);

  localparam int unsigned H   = k2red_half(LOG_Q);
  localparam int unsigned Lat = k2red_mult_lat(SPEED_OPT);
  localparam int unsigned SbW = 2 + LOG_Q + 3 * LOG_L;

  logic [LOG_Q-1:0]   x_q, y_q;
  logic [SbW-1:0]     sb_d;
  logic [SbW-1:0]     sb_q [Lat];
  logic               rf;
  logic [H-1:0]       xh, xl, yh, yl;
  logic [2*H-1:0]     p_hh_s, p_hl_s, p_lh_s, p_ll_s;
  logic [2*H-1:0]     p_hh_m, p_hl_m, p_lh_m, p_ll_m;
  logic [2*H:0]       mid;
  logic [2*LOG_Q-1:0] a_d, a_q;

  assign rf   = (bus.X >= bus.Q) | (bus.Y >= bus.Q);
  assign sb_d = {bus.in_valid, rf, bus.Q, bus.l1, bus.l2, bus.l3};

  // Valid/sideband delay line: entry 0 is the input stage, last entry drives the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      for (int i = 0; i < Lat; i++) sb_q[i] <= '0;
    end else begin
      x_q     <= bus.X;
      y_q     <= bus.Y;
      sb_q[0] <= sb_d;
      for (int i = 1; i < Lat; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  assign {xh, xl} = x_q;
  assign {yh, yl} = y_q;

  k2red_pmul_half #(.H(H)) u_mul_hh (.clk(clk), .a_i(xh), .b_i(yh), .p_o(p_hh_s));
  k2red_pmul_half #(.H(H)) u_mul_hl (.clk(clk), .a_i(xh), .b_i(yl), .p_o(p_hl_s));
  k2red_pmul_half #(.H(H)) u_mul_lh (.clk(clk), .a_i(xl), .b_i(yh), .p_o(p_lh_s));
  k2red_pmul_half #(.H(H)) u_mul_ll (.clk(clk), .a_i(xl), .b_i(yl), .p_o(p_ll_s));

  if (SPEED_OPT != 0) begin : g_speed
    logic [2*H-1:0] p_hh_q, p_hl_q, p_lh_q, p_ll_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        p_hh_q <= '0;
        p_hl_q <= '0;
        p_lh_q <= '0;
        p_ll_q <= '0;
      end else begin
        p_hh_q <= p_hh_s;
        p_hl_q <= p_hl_s;
        p_lh_q <= p_lh_s;
        p_ll_q <= p_ll_s;
      end
    end

    assign p_hh_m = p_hh_q;
    assign p_hl_m = p_hl_q;
    assign p_lh_m = p_lh_q;
    assign p_ll_m = p_ll_q;
  end else begin : g_fast
    assign p_hh_m = p_hh_s;
    assign p_hl_m = p_hl_s;
    assign p_lh_m = p_lh_s;
    assign p_ll_m = p_ll_s;
  end

  // hh and ll occupy disjoint bit ranges, so they concatenate; only the cross terms add.
  assign mid = {1'b0, p_hl_m} + {1'b0, p_lh_m};
  assign a_d = {p_hh_m, p_ll_m} + {{(H-1){1'b0}}, mid, {H{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) a_q <= '0;
    else     a_q <= a_d;
  end

  assign bus.A = a_q;
  assign {bus.out_valid, bus.range_err, bus.Q_o, bus.l1_o, bus.l2_o, bus.l3_o} = sb_q[Lat-1];

endmodule
